// File: rtl/fft_sample_loader.sv
// fft_sample_loader: gathers one frame of real samples into a buffer in
// bit-reversed order. It then presents the even/odd operand pairs for the
// base-case butterfly stage of FFT_Calc. The imaginary parts are zero, and
// no twiddle output is needed because the base-case twiddle is W^0.
module fft_sample_loader #(
  parameter int sample_size = 32,
  parameter int buffer_size = 8,
  localparam int addr_width = $clog2(buffer_size),
  localparam int pair_width = (addr_width > 1) ? addr_width - 1 : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [sample_size-1:0] in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [sample_size-1:0] out_even_real,
  output logic signed [sample_size-1:0] out_even_imag,
  output logic signed [sample_size-1:0] out_odd_real,
  output logic signed [sample_size-1:0] out_odd_imag,
  output logic [pair_width-1:0]         out_pair_index,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_done
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [addr_width-1:0] LAST_WR = addr_width'(buffer_size - 1);
  localparam logic [pair_width-1:0] LAST_RD = pair_width'(buffer_size / 2 - 1);

  state_t                        state_q, state_d;
  logic [addr_width-1:0]         wr_cnt_q, wr_cnt_d;
  logic [pair_width-1:0]         rd_cnt_q, rd_cnt_d;
  logic                          frame_done_q, frame_done_d;
  logic signed [sample_size-1:0] buf_q [buffer_size];
  logic                          wr_en;
  logic [addr_width-1:0]         wr_addr;
  logic [addr_width-1:0]         ev_idx;
  logic [addr_width-1:0]         od_idx;

  // Reverses the index bits, so that sequential arrivals land in butterfly order.
  function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] idx);
    logic [addr_width-1:0] r;
    for (int b = 0; b < addr_width; b++) r[b] = idx[addr_width-1-b];
    return r;
  endfunction

  assign wr_addr = bitrev(wr_cnt_q);
  // The two members of a pair are adjacent buffer slots 2k and 2k+1.
  assign ev_idx  = addr_width'({rd_cnt_q, 1'b0});
  assign od_idx  = ev_idx | addr_width'(1);

  // State, counters, done pulse and sample buffer; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < buffer_size; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_done_q <= frame_done_d;
      if (wr_en) buf_q[wr_addr] <= in_sample;
    end
  end

  // Next-state logic: fill a whole frame, then drain every pair, then refill.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_WR) begin
            wr_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + addr_width'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_cnt_q == LAST_RD) begin
            rd_cnt_d     = '0;
            state_d      = FILL;
            frame_done_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + pair_width'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the handshake follows the state, and the data is forced to zero outside DRAIN.
  always_comb begin
    in_ready       = (state_q == FILL);
    out_valid      = (state_q == DRAIN);
    out_even_real  = '0;
    out_odd_real   = '0;
    out_pair_index = '0;
    out_even_imag  = '0;
    out_odd_imag   = '0;
    if (state_q == DRAIN) begin
      out_even_real  = buf_q[ev_idx];
      out_odd_real   = buf_q[od_idx];
      out_pair_index = rd_cnt_q;
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader. There are two instances: one with
// N=8 and one with N=2. Expected pairs go into queues when a frame is issued,
// and monitors pop the queues and compare on every accepted pair.
module tb_fft_sample_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic signed [31:0] a_in_sample, a_er, a_ei, a_or, a_oi;
  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_fd;
  logic [1:0]         a_idx;

  logic signed [31:0] b_in_sample, b_er, b_ei, b_or, b_oi;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fd;
  logic [0:0]         b_idx;

  fft_sample_loader #(.sample_size(32), .buffer_size(8)) dut_a (
    .clk(clk), .reset(reset), .in_sample(a_in_sample), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_even_real(a_er), .out_even_imag(a_ei),
    .out_odd_real(a_or), .out_odd_imag(a_oi), .out_pair_index(a_idx),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .frame_done(a_fd));

  fft_sample_loader #(.sample_size(32), .buffer_size(2)) dut_b (
    .clk(clk), .reset(reset), .in_sample(b_in_sample), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_even_real(b_er), .out_even_imag(b_ei),
    .out_odd_real(b_or), .out_odd_imag(b_oi), .out_pair_index(b_idx),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .frame_done(b_fd));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    logic signed [31:0] ev;
    logic signed [31:0] od;
    int                 k;
  } pair_t;

  pair_t qa[$];
  pair_t qb[$];

  task automatic push_a(input logic signed [31:0] ev, input logic signed [31:0] od, input int k);
    pair_t p;
    p.ev = ev; p.od = od; p.k = k;
    qa.push_back(p);
  endtask

  task automatic push_b(input logic signed [31:0] ev, input logic signed [31:0] od);
    pair_t p;
    p.ev = ev; p.od = od; p.k = 0;
    qb.push_back(p);
  endtask

  // Monitor for the N=8 instance
  bit                 a_exp_fd  = 1'b0;
  bit                 a_stalled = 1'b0;
  logic signed [31:0] a_pe, a_po;
  logic [1:0]         a_pk;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      a_exp_fd  = 1'b0;
      a_stalled = 1'b0;
    end else begin
      check("a_even_imag", a_ei, 0);
      check("a_odd_imag", a_oi, 0);
      check("a_frame_done", a_fd, a_exp_fd);
      if (a_exp_fd) check("a_in_ready_with_done", a_in_ready, 1);
      a_exp_fd = 1'b0;
      if (!a_out_valid) begin
        check("a_even_zero_idle", a_er, 0);
        check("a_odd_zero_idle", a_or, 0);
      end
      if (a_stalled) begin
        check("a_hold_valid", a_out_valid, 1);
        check("a_hold_even", a_er, a_pe);
        check("a_hold_odd", a_or, a_po);
        check("a_hold_index", a_idx, a_pk);
      end
      a_stalled = a_out_valid && !a_out_ready;
      a_pe = a_er; a_po = a_or; a_pk = a_idx;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          check("a_unexpected_pair", 1, 0);
        end else begin
          pair_t p;
          p = qa.pop_front();
          check("a_pair_even", a_er, p.ev);
          check("a_pair_odd", a_or, p.od);
          check("a_pair_index", a_idx, p.k);
        end
        if (a_idx == 2'd3) a_exp_fd = 1'b1;
      end
    end
  end

  // Monitor for the N=2 instance
  bit b_exp_fd = 1'b0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      b_exp_fd = 1'b0;
    end else begin
      check("b_frame_done", b_fd, b_exp_fd);
      if (b_exp_fd) check("b_in_ready_with_done", b_in_ready, 1);
      b_exp_fd = 1'b0;
      if (b_out_valid && b_out_ready) begin
        check("b_even_imag", b_ei, 0);
        check("b_odd_imag", b_oi, 0);
        if (qb.size() == 0) begin
          check("b_unexpected_pair", 1, 0);
        end else begin
          pair_t p;
          p = qb.pop_front();
          check("b_pair_even", b_er, p.ev);
          check("b_pair_odd", b_or, p.od);
          check("b_pair_index", b_idx, p.k);
        end
        b_exp_fd = 1'b1;
      end
    end
  end

  logic signed [31:0] xs [8];

  // Streams xs[0..n-1]; in gap mode in_valid alternates 1/0 each cycle.
  task automatic fill_a(input int n, input bit gaps, input bit latency_check);
    int i = 0;
    bit tog = 1'b0;
    a_out_ready = 1'b0;
    for (int c = 0; c < 200 && i < n; c++) begin
      @(negedge clk);
      if (gaps && tog) begin
        a_in_valid = 1'b0;
        tog = 1'b0;
      end else begin
        a_in_valid  = 1'b1;
        a_in_sample = xs[i];
        tog = 1'b1;
      end
      #1;
      check("a_no_early_pair", a_out_valid, 0);
      if (a_in_valid && a_in_ready) i++;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    check("a_fill_accepts", i, n);
    if (latency_check) check("a_valid_after_last_accept", a_out_valid, 1);
  endtask

  // Drains four pairs; it holds out_ready low for stall_n cycles while pair stall_k is shown.
  task automatic drain_a(input int stall_k, input int stall_n);
    int held = 0;
    int got  = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      if (a_out_valid && int'(a_idx) == stall_k && held < stall_n) begin
        a_out_ready = 1'b0;
        held++;
      end else begin
        a_out_ready = 1'b1;
      end
      if (a_out_valid && a_out_ready) got++;
    end
    check("a_drain_pairs", got, 4);
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic frame_b(input logic signed [31:0] x0, input logic signed [31:0] x1);
    int i = 0;
    for (int c = 0; c < 50 && i < 2; c++) begin
      @(negedge clk);
      b_in_valid  = 1'b1;
      b_in_sample = (i == 0) ? x0 : x1;
      #1;
      check("b_no_early_pair", b_out_valid, 0);
      if (b_in_ready) i++;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    check("b_fill_accepts", i, 2);
    check("b_valid_after_last_accept", b_out_valid, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    a_in_sample = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_sample = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_frame_done", a_fd, 0);
    check("rst_even", a_er, 0);
    check("rst_odd", a_or, 0);
    check("rst_index", a_idx, 0);
    check("rst_b_in_ready", b_in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_in_ready", a_in_ready, 0);

    // Back-to-back frame x_i = 10*i
    for (int i = 0; i < 8; i++) xs[i] = 32'(10 * i);
    push_a(0, 40, 0); push_a(20, 60, 1); push_a(10, 50, 2); push_a(30, 70, 3);
    fill_a(8, 1'b0, 1'b1);
    drain_a(-1, 0);

    // Backpressure at pair 1 for three cycles
    push_a(0, 40, 0); push_a(20, 60, 1); push_a(10, 50, 2); push_a(30, 70, 3);
    fill_a(8, 1'b0, 1'b1);
    drain_a(1, 3);

    // Input gaps, x_i = i
    for (int i = 0; i < 8; i++) xs[i] = 32'(i);
    push_a(0, 4, 0); push_a(2, 6, 1); push_a(1, 5, 2); push_a(3, 7, 3);
    fill_a(8, 1'b1, 1'b1);
    drain_a(-1, 0);

    // Signed extremes
    xs[0] = -32768; xs[1] = 32'sh7fffffff; xs[2] = -1; xs[3] = 1;
    xs[4] = 32'sh80000000; xs[5] = 5; xs[6] = 0; xs[7] = -7;
    push_a(-32768, 32'sh80000000, 0); push_a(-1, 0, 1);
    push_a(32'sh7fffffff, 5, 2); push_a(1, -7, 3);
    fill_a(8, 1'b0, 1'b1);
    drain_a(-1, 0);

    // Reset partway through a fill, then a fresh frame
    for (int i = 0; i < 8; i++) xs[i] = 32'(200 + i);
    fill_a(5, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", a_in_ready, 0);
    check("midrst_out_valid", a_out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) xs[i] = 32'(100 + i);
    push_a(100, 104, 0); push_a(102, 106, 1); push_a(101, 105, 2); push_a(103, 107, 3);
    fill_a(8, 1'b0, 1'b1);
    drain_a(-1, 0);

    // N=2 instance, two frames
    push_b(7, -3);
    frame_b(7, -3);
    push_b(11, -12);
    frame_b(11, -12);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
